// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, digit maxima and clamp helper for the countdown timer
package timer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9, SEC_TENS_MAX = 4'd5, MIN_MAX = 4'd9;
  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return v > mx ? mx : v;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one loadable BCD down-counting digit that wraps to MAX and borrows on zero
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       is_zero,
  output logic       borrow_out
);
  assign is_zero = digit == 4'd0;
  assign borrow_out = dec_en & is_zero;
  always_ff @(negedge clk or posedge reset)
    if (reset) digit <= 4'd0;
    else if (load) digit <= load_val;
    else if (dec_en) digit <= is_zero ? MAX : digit - 4'd1;
endmodule

// File: rtl/mins_countdown_timer.sv
// mins_countdown_timer: loadable M:SS countdown with prescaled ticks, pause/resume and expiry flags
module mins_countdown_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_out,
  output logic [3:0] sec_tens_out,
  output logic [3:0] sec_ones_out,
  output logic       running,
  output logic       expired,
  output logic       expired_pulse
);
  localparam int PW = $clog2(PRESCALE);
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic tick, last, all_zero;
  logic z_ones, z_tens, z_min, b_ones, b_tens, b_min;
  assign tick = state == RUN && !load && !pause && presc == PW'(PRESCALE - 1);
  assign all_zero = z_ones & z_tens & z_min;
  // the decrement from 0:01 is the one that lands on 0:00
  assign last = tick & z_min & z_tens & (sec_ones_out == 4'd1);
  bcd_down_digit #(.MAX(SEC_ONES_MAX)) u_ones (
    .clk(clk), .reset(reset), .dec_en(tick), .load(load),
    .load_val(clamp(load_sec_ones, SEC_ONES_MAX)),
    .digit(sec_ones_out), .is_zero(z_ones), .borrow_out(b_ones)
  );
  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_tens (
    .clk(clk), .reset(reset), .dec_en(b_ones), .load(load),
    .load_val(clamp(load_sec_tens, SEC_TENS_MAX)),
    .digit(sec_tens_out), .is_zero(z_tens), .borrow_out(b_tens)
  );
  bcd_down_digit #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .dec_en(b_tens), .load(load),
    .load_val(clamp(load_min, MIN_MAX)),
    .digit(min_out), .is_zero(z_min), .borrow_out(b_min)
  );
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      expired_pulse <= 1'b0;
    end else begin
      state <= state_n;
      expired_pulse <= state_n == DONE && state != DONE;
      if (load) presc <= '0;
      else if (state == RUN && !pause) presc <= tick ? '0 : presc + PW'(1);
    end
  // a minutes borrow would mean underflow; treat it as expiry so the value never wraps
  always_comb begin
    state_n = state;
    if (load) state_n = IDLE;
    else
      case (state)
        IDLE:    if (start) state_n = all_zero ? DONE : RUN;
        RUN:     state_n = pause ? PAUSE : (last | b_min) ? DONE : RUN;
        PAUSE:   if (start && !pause) state_n = RUN;
        default: state_n = DONE;
      endcase
  end
  always_comb begin
    running = state == RUN;
    expired = state == DONE;
  end
endmodule

// File: tb/tb_mins_countdown_timer.sv
// tb_mins_countdown_timer: vector table, directed corner sequences and random stimulus vs a seconds-based model
module tb_mins_countdown_timer;
  localparam int P = 4;
  logic clk = 1'b0, reset, load, start, pause;
  logic [3:0] load_min, load_sec_tens, load_sec_ones;
  logic [3:0] min_out, sec_tens_out, sec_ones_out;
  logic running, expired, expired_pulse;
  int errors = 0, checks = 0;
  int m_secs, m_st, m_presc;
  bit m_pulse;

  typedef struct {
    logic ld;
    logic [3:0] m, t, o;
    logic s, p;
    logic [14:0] exp;
  } vec_t;
  vec_t vecs[$];

  mins_countdown_timer #(.PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min),
    .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
    .start(start), .pause(pause), .min_out(min_out), .sec_tens_out(sec_tens_out),
    .sec_ones_out(sec_ones_out), .running(running), .expired(expired),
    .expired_pulse(expired_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] dut_v();
    return {min_out, sec_tens_out, sec_ones_out, running, expired, expired_pulse};
  endfunction

  function automatic logic [14:0] model_v();
    return {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
            m_st == 1, m_st == 3, m_pulse};
  endfunction

  function automatic int cl(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction

  task automatic chk(input string n, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_st = 0; m_presc = 0; m_pulse = 0;
  endtask

  // model states: 0 idle, 1 run, 2 pause, 3 done; value held as total seconds
  task automatic model_edge();
    m_pulse = 0;
    if (load) begin
      m_secs = cl(load_min, 9) * 60 + cl(load_sec_tens, 5) * 10 + cl(load_sec_ones, 9);
      m_presc = 0;
      m_st = 0;
    end else if (m_st == 0) begin
      if (start) begin
        if (m_secs == 0) begin m_st = 3; m_pulse = 1; end
        else begin m_st = 1; m_presc = 0; end
      end
    end else if (m_st == 1) begin
      if (pause) m_st = 2;
      else if (m_presc == P - 1) begin
        m_presc = 0;
        m_secs--;
        if (m_secs == 0) begin m_st = 3; m_pulse = 1; end
      end else m_presc++;
    end else if (m_st == 2) begin
      if (start && !pause) m_st = 1;
    end
  endtask

  // called at a rising edge; the DUT acts on the following falling edge
  task automatic step(input logic ld, input logic [3:0] m, t, o, input logic s, p);
    load = ld; load_min = m; load_sec_tens = t; load_sec_ones = o; start = s; pause = p;
    model_edge();
    @(negedge clk);
    @(posedge clk);
    chk("model", dut_v(), model_v());
    chk("bcd_legal", 15'({min_out <= 9, sec_tens_out <= 5, sec_ones_out <= 9}), 15'b111);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; load = 0; start = 0; pause = 0;
    load_min = 0; load_sec_tens = 0; load_sec_ones = 0;
    model_reset();
    vecs.push_back('{1, 12, 7, 15, 0, 0, {4'd9, 4'd5, 4'd9, 3'b000}});
    vecs.push_back('{1, 5, 9, 9, 0, 0, {4'd5, 4'd5, 4'd9, 3'b000}});
    vecs.push_back('{1, 0, 0, 0, 0, 0, {4'd0, 4'd0, 4'd0, 3'b000}});
    vecs.push_back('{0, 0, 0, 0, 1, 0, {4'd0, 4'd0, 4'd0, 3'b011}});
    vecs.push_back('{0, 0, 0, 0, 1, 0, {4'd0, 4'd0, 4'd0, 3'b010}});
    vecs.push_back('{0, 0, 0, 0, 0, 1, {4'd0, 4'd0, 4'd0, 3'b010}});
    vecs.push_back('{1, 2, 3, 1, 0, 0, {4'd2, 4'd3, 4'd1, 3'b000}});
    vecs.push_back('{0, 0, 0, 0, 1, 0, {4'd2, 4'd3, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 1, 1, {4'd2, 4'd3, 4'd1, 3'b000}});
    vecs.push_back('{0, 0, 0, 0, 0, 1, {4'd2, 4'd3, 4'd1, 3'b000}});
    vecs.push_back('{0, 0, 0, 0, 1, 0, {4'd2, 4'd3, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd2, 4'd3, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd2, 4'd3, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd2, 4'd3, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd2, 4'd3, 4'd0, 3'b100}});
    vecs.push_back('{1, 0, 0, 1, 0, 0, {4'd0, 4'd0, 4'd1, 3'b000}});
    vecs.push_back('{0, 0, 0, 0, 1, 0, {4'd0, 4'd0, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd0, 4'd0, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd0, 4'd0, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd0, 4'd0, 4'd1, 3'b100}});
    vecs.push_back('{0, 0, 0, 0, 0, 0, {4'd0, 4'd0, 4'd0, 3'b011}});
    vecs.push_back('{0, 0, 0, 0, 1, 0, {4'd0, 4'd0, 4'd0, 3'b010}});
    @(posedge clk);
    @(posedge clk);
    reset = 0;
    chk("reset_state", dut_v(), 15'd0);

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].m, vecs[i].t, vecs[i].o, vecs[i].s, vecs[i].p);
      chk($sformatf("vec%0d", i), dut_v(), vecs[i].exp);
    end

    // full countdown from 1:00
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 240; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (k == 4) chk("t2_0059", dut_v(), {4'd0, 4'd5, 4'd9, 3'b100});
      if (k == 40) chk("t2_0050", dut_v(), {4'd0, 4'd5, 4'd0, 3'b100});
      if (k == 240) chk("t2_expire", dut_v(), {4'd0, 4'd0, 4'd0, 3'b011});
    end
    idle(3);
    chk("t2_held", dut_v(), {4'd0, 4'd0, 4'd0, 3'b010});

    // pause holds value and prescaler
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(6);
    chk("t3_pre_pause", dut_v(), {4'd0, 4'd0, 4'd9, 3'b100});
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("t3_hold", dut_v(), {4'd0, 4'd0, 4'd9, 3'b000});
    end
    step(0, 0, 0, 0, 1, 0);
    idle(1);
    chk("t3_resume1", dut_v(), {4'd0, 4'd0, 4'd9, 3'b100});
    idle(1);
    chk("t3_resume2", dut_v(), {4'd0, 4'd0, 4'd8, 3'b100});

    // asynchronous reset in the middle of a run
    step(1, 0, 4, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(12);
    chk("t1_0037", dut_v(), {4'd0, 4'd3, 4'd7, 3'b100});
    idle(2);
    #2 reset = 1;
    #1 chk("t1_async", dut_v(), 15'd0);
    @(posedge clk);
    reset = 0;
    model_reset();
    idle(2);
    chk("t1_after", dut_v(), 15'd0);

    for (int i = 0; i < 500; i++) begin
      logic ld;
      ld = $urandom_range(0, 19) == 0;
      step(ld, $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'd0,
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
